dmem_arbiter: RTL and testbench

- Shares the single-port word-addressed data memory between two requesters: M0, the pipeline load/store port, and M1, the loader/debug port.
- One single-cycle access is granted per cycle, by round-robin.
- A requester may lock the memory for atomic read-modify-write sequences; a lock timeout prevents starvation.
- Misaligned and out-of-range accesses are rejected before they reach memory. Responses are registered.

---
 rtl/dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters,
// with an atomic lock (bounded by a timeout), bad-address rejection and registered responses.
module dmem_arbiter #(
  parameter int DEPTH_WORDS = 64,
  parameter int MAX_LOCK    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam int             CW      = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_LOCK);
  localparam logic [29:0]    DEPTH_W = 30'(DEPTH_WORDS);

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_prio;      // requester that wins the next tie

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_any;
  logic          w_sel;
  logic          w_we;
  logic          w_lock;
  logic          w_bad;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_own_sel;
  logic          w_own_req;
  logic          w_own_lock;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      ST_OWN0: w_gnt0 = m0_req;
      ST_OWN1: w_gnt1 = m1_req;
      default: begin
        if (m0_req && m1_req) begin
          w_gnt0 = ~r_prio;
          w_gnt1 = r_prio;
        end else begin
          w_gnt0 = m0_req;
          w_gnt1 = m1_req;
        end
      end
    endcase
    // Grants are suppressed while reset is held so the memory sees no access.
    if (!reset_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_any   = w_gnt0 | w_gnt1;
  assign w_sel   = w_gnt1;
  assign w_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_wdata = w_sel ? m1_wdata : m0_wdata;
  assign w_we    = w_sel ? m1_we    : m0_we;
  assign w_lock  = w_sel ? m1_lock  : m0_lock;
  assign w_bad   = (|w_addr[1:0]) | (w_addr[31:2] >= DEPTH_W);

  assign w_own_sel  = r_state[1];
  assign w_own_req  = w_own_sel ? m1_req  : m0_req;
  assign w_own_lock = w_own_sel ? m1_lock : m0_lock;

  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;
  assign mem_we = w_any & w_we & ~w_bad;
  assign mem_a  = w_any ? w_addr  : 32'h0;
  assign mem_wd = w_any ? w_wdata : 32'h0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_prio  <= 1'b0;
    end else begin
      if (w_any) r_prio <= ~w_sel;
      case (r_state)
        ST_IDLE: begin
          // An errored access cannot acquire the lock.
          if (w_any && w_lock && !w_bad) begin
            r_state <= w_sel ? ST_OWN1 : ST_OWN0;
            r_cnt   <= CNT_ONE;
          end
        end
        default: begin
          if (r_cnt == CNT_MAX) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_prio  <= ~w_own_sel;
          end else if ((w_any && !w_lock && !w_bad) || (!w_own_req && !w_own_lock)) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= 32'h0;
    end else begin
      m0_rvalid <= w_gnt0;
      m0_err    <= w_gnt0 & w_bad;
      m0_rdata  <= (w_gnt0 && !w_we && !w_bad) ? mem_rd : 32'h0;
      m1_rvalid <= w_gnt1;
      m1_err    <= w_gnt1 & w_bad;
      m1_rdata  <= (w_gnt1 && !w_we && !w_bad) ? mem_rd : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, all compared per cycle
// against a reference model of arbitration, locking, memory contents and responses.
module tb_dmem_arbiter;

  localparam int DEPTH = 64;
  localparam int MAXL  = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        t_req  [2];
  logic        t_we   [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wd   [2];
  logic        t_lock [2];

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH_WORDS(DEPTH), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(t_req[0]), .m0_we(t_we[0]), .m0_addr(t_addr[0]), .m0_wdata(t_wd[0]), .m0_lock(t_lock[0]),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(t_req[1]), .m1_we(t_we[1]), .m1_addr(t_addr[1]), .m1_wdata(t_wd[1]), .m1_lock(t_lock[1]),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory attached to the arbiter
  logic [31:0] dmem [DEPTH];
  always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = dmem[mem_a[7:2]];

  // Reference model
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [DEPTH];
  int          ref_owner, ref_cnt, ref_fav, ref_g;
  logic        exp_rv  [2];
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_owner = -1;
    ref_cnt   = 0;
    ref_fav   = 0;
    ref_g     = -1;
    for (int n = 0; n < 2; n++) begin
      exp_rv[n] = 1'b0; exp_err[n] = 1'b0; exp_rd[n] = 32'h0;
    end
  endtask

  task automatic set_m(input int n, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic l);
    t_req[n] = r; t_we[n] = w; t_addr[n] = a; t_wd[n] = d; t_lock[n] = l;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m0_gnt"},    32'(m0_gnt),    32'h0);
    check({tag, "_m1_gnt"},    32'(m1_gnt),    32'h0);
    check({tag, "_mem_we"},    32'(mem_we),    32'h0);
    check({tag, "_mem_a"},     mem_a,          32'h0);
    check({tag, "_mem_wd"},    mem_wd,         32'h0);
    check({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'h0);
    check({tag, "_m0_rdata"},  m0_rdata,       32'h0);
    check({tag, "_m0_err"},    32'(m0_err),    32'h0);
    check({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'h0);
    check({tag, "_m1_rdata"},  m1_rdata,       32'h0);
    check({tag, "_m1_err"},    32'(m1_err),    32'h0);
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    int          g, n;
    logic        bad, exp_we;
    logic [31:0] a, d;
    @(negedge clk);
    if (ref_owner >= 0)            g = t_req[ref_owner] ? ref_owner : -1;
    else if (t_req[0] && t_req[1]) g = ref_fav;
    else if (t_req[0])             g = 0;
    else if (t_req[1])             g = 1;
    else                           g = -1;
    ref_g  = g;
    a      = 32'h0;
    d      = 32'h0;
    bad    = 1'b0;
    exp_we = 1'b0;
    if (g >= 0) begin
      a      = t_addr[g];
      d      = t_wd[g];
      bad    = (a % 4 != 0) || (a / 4 >= DEPTH);
      exp_we = t_we[g] && !bad;
    end
    check("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    check("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    check("mem_a",  mem_a, a);
    check("mem_wd", mem_wd, d);
    check("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
    check("m0_err",    32'(m0_err),    32'(exp_err[0]));
    check("m0_rdata",  m0_rdata,       exp_rd[0]);
    check("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
    check("m1_err",    32'(m1_err),    32'(exp_err[1]));
    check("m1_rdata",  m1_rdata,       exp_rd[1]);

    for (int k = 0; k < 2; k++) begin
      exp_rv[k] = 1'b0; exp_err[k] = 1'b0; exp_rd[k] = 32'h0;
    end
    if (g >= 0) begin
      exp_rv[g]  = 1'b1;
      exp_err[g] = bad;
      if (!t_we[g] && !bad) exp_rd[g] = ref_mem[a / 4];
      if (t_we[g] && !bad)  ref_mem[a / 4] = d;
      ref_fav = 1 - g;
    end
    if (ref_owner < 0) begin
      if (g >= 0 && t_lock[g] && !bad) begin
        ref_owner = g;
        ref_cnt   = 1;
      end
    end else begin
      n = ref_owner;
      if (ref_cnt == MAXL) begin
        ref_owner = -1;
        ref_fav   = 1 - n;
      end else if ((g == n && !t_lock[n] && !bad) || (!t_req[n] && !t_lock[n])) begin
        ref_owner = -1;
      end else begin
        ref_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_fields(input int n);
    int          kind;
    logic [31:0] a;
    kind = int'($urandom_range(0, 7));
    a    = 32'($urandom_range(0, DEPTH - 1)) * 4;
    if (kind == 0)      a = a + 32'($urandom_range(1, 3));
    else if (kind == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 4;
    else if (kind == 2) a = $urandom() | 32'h8000_0000;
    set_m(n, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom(),
          $urandom_range(0, 3) == 0);
  endtask

  initial begin
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    model_reset();
    #1 reset_n = 1'b0;
    #2 check_all_zero("rst_init");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // First tie after reset goes to M0 (memory contents unknown, so rdata compared after init)
    cycle();
    check("first_tie_m0_rvalid", 32'(m0_rvalid), 32'h1);
    check("first_tie_m1_rvalid", 32'(m1_rvalid), 32'h0);

    // Fill memory through M1
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      set_m(1, 1'b1, 1'b1, 32'(i * 4), $urandom(), 1'b0);
      cycle();
    end

    // Round-robin with both reading continuously
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    repeat (8) cycle();

    // Write by M1 then read by M0
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF, 1'b0);
    cycle();
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    cycle();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check("wr_rd_data", m0_rdata, 32'hDEADBEEF);
    check("wr_rd_err",  32'(m0_err), 32'h0);
    cycle();

    // Misaligned and out-of-range writes
    set_m(0, 1'b1, 1'b1, 32'h102, 32'h1234, 1'b0);
    cycle();
    check("misalign_err", 32'(m0_err), 32'h1);
    set_m(0, 1'b1, 1'b1, 32'h100, 32'h1234, 1'b0);
    cycle();
    check("range_err", 32'(m0_err), 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      set_m(0, 1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0);
      cycle();
    end

    // Lock held across idle cycles, released by the unlocking write
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    cycle();
    set_m(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    cycle();
    set_m(0, 1'b0, 1'b0, 32'h4, 32'h0, 1'b1);
    repeat (2) cycle();
    set_m(0, 1'b1, 1'b1, 32'h4, 32'hA5A5_0004, 1'b0);
    cycle();
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle();
    check("unlock_m1_granted", 32'(m1_rvalid), 32'h1);

    // Lock held continuously until the timeout forces release
    set_m(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    repeat (9) cycle();
    check("lock_hold_m1_waits", 32'(m1_rvalid), 32'h0);
    cycle();
    check("forced_release_m1", 32'(m1_rvalid), 32'h1);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) cycle();

    // Random traffic; a pending request keeps its fields until granted
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++)
        if (!t_req[n] || ref_g == n) rand_fields(n);
      cycle();
    end

    // Reset in the middle of traffic, then the first tie goes to M0
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    #1 reset_n = 1'b0;
    #1 check_all_zero("rst_mid");
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    set_m(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    cycle();
    check("post_rst_m0_first", 32'(m0_rvalid), 32'h1);
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
